// File: rtl/scan_mux.sv
// scan_mux: N-channel W-bit registered mux with manual load select or auto round-robin scan.
// Define SCAN_MASK_EN to add a ch_mask input that skips disabled channels.
module scan_mux #(
  parameter int N = 4,
  parameter int W = 1,
  parameter int DWELL = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] data_in,
  input  logic           mode,
  input  logic           load,
  input  logic [SW-1:0]  sel,
`ifdef SCAN_MASK_EN
  input  logic [N-1:0]   ch_mask,
`endif
  output logic [W-1:0]   data_out,
  output logic [SW-1:0]  ch_out,
  output logic           valid
);
  localparam int CW = $clog2(DWELL + 1);
  localparam int NP = 1 << SW;
  logic [N-1:0] en;
  logic [NP-1:0] en_x;
  logic [SW-1:0] ch_q, ch_d, step_ch, cand;
  logic [W-1:0] data_q, data_d;
  logic valid_q, valid_d, step, step_ok, accept;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef SCAN_MASK_EN
  assign en = ch_mask;
`else
  assign en = '1;
`endif
  // Indices at or above N map to zero bits, so out-of-range sel is rejected by the mask lookup.
  assign en_x = NP'(en);
  assign step = cnt_q == CW'(DWELL - 1);
  assign accept = load & en_x[sel];
  // Search downward so the nearest enabled channel after ch_q wins; ch_q itself is the fallback.
  always_comb begin
    step_ch = ch_q;
    step_ok = en_x[ch_q];
    cand = ch_q;
    for (int i = N - 1; i >= 1; i--) begin
      cand = SW'((int'(ch_q) + i) % N);
      if (en_x[cand]) begin
        step_ch = cand;
        step_ok = 1'b1;
      end
    end
  end
  always_comb begin
    ch_d = mode ? (step & step_ok ? step_ch : ch_q) : (accept ? sel : ch_q);
    valid_d = mode ? step & step_ok : accept;
    cnt_d = mode & ~step ? cnt_q + CW'(1) : '0;
    data_d = data_in[int'(ch_d)*W +: W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ch_q <= ch_d;
      data_q <= data_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  end
  assign data_out = data_q;
  assign ch_out = ch_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed stimulus for scan_mux, checked every cycle against a behavioural model plus literal spot checks.
module tb_scan_mux;
  localparam int N = 4, W = 1, DWELL = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N*W-1:0] data_in = 4'b0110;
  logic mode = 1'b0, load = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [W-1:0] data_out;
  logic [1:0] ch_out;
  logic valid;
  logic [5:0] d2_in = {2'd3, 2'd2, 2'd1};
  logic d2_mode = 1'b0, d2_load = 1'b0;
  logic [1:0] d2_sel = 2'd0, d2_out, d2_ch;
  logic d2_valid;
`ifdef SCAN_MASK_EN
  logic [N-1:0] ch_mask = '1;
  logic [2:0] d2_mask = '1;
`endif
  int n_cmp = 0, n_err = 0;
  logic chk_en = 1'b0;

  scan_mux #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .mode(mode), .load(load), .sel(sel),
`ifdef SCAN_MASK_EN
    .ch_mask(ch_mask),
`endif
    .data_out(data_out), .ch_out(ch_out), .valid(valid)
  );

  scan_mux #(.N(3), .W(2), .DWELL(1)) dut2 (
    .clk(clk), .rst(rst), .data_in(d2_in), .mode(d2_mode), .load(d2_load), .sel(d2_sel),
`ifdef SCAN_MASK_EN
    .ch_mask(d2_mask),
`endif
    .data_out(d2_out), .ch_out(d2_ch), .valid(d2_valid)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit enabled(input int c);
    if (c >= N) return 1'b0;
`ifdef SCAN_MASK_EN
    return ch_mask[c];
`else
    return 1'b1;
`endif
  endfunction

  function automatic int next_enabled(input int c);
    for (int off = 1; off <= N; off++)
      if (enabled((c + off) % N)) return (c + off) % N;
    return -1;
  endfunction

  // Model: age counts cycles spent in auto mode since the last step; a step fires when DWELL cycles have elapsed.
  int m_ch = 0, m_age = 0, nxt;
  logic [W-1:0] m_data = '0;
  logic m_valid = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_ch = 0;
      m_age = 0;
      m_valid = 1'b0;
    end else if (mode) begin
      m_valid = 1'b0;
      m_age++;
      if (m_age == DWELL) begin
        m_age = 0;
        nxt = next_enabled(m_ch);
        if (nxt >= 0) begin
          m_ch = nxt;
          m_valid = 1'b1;
        end
      end
    end else begin
      m_age = 0;
      m_valid = load && enabled(int'(sel));
      if (m_valid) m_ch = int'(sel);
    end
    m_data = rst ? '0 : data_in[m_ch*W +: W];
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model ch_out", int'(ch_out), m_ch);
      cmp("model data_out", int'(data_out), int'(m_data));
      cmp("model valid", int'(valid), int'(m_valid));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    step(2);
    cmp("rst ch_out", int'(ch_out), 0);
    cmp("rst data_out", int'(data_out), 0);
    cmp("rst valid", int'(valid), 0);
    rst = 1'b0;
    step(1);
    cmp("post-rst data_out", int'(data_out), 0);
    sel = 2'd1; load = 1'b1;
    step(1);
    cmp("load1 ch_out", int'(ch_out), 1);
    cmp("load1 data_out", int'(data_out), 1);
    cmp("load1 valid", int'(valid), 1);
    load = 1'b0;
    step(1);
    cmp("load1 valid drop", int'(valid), 0);
    sel = 2'd3; load = 1'b1;
    step(1);
    cmp("load3 data_out", int'(data_out), 0);
    load = 1'b0;
    step(1);
    sel = 2'd2; load = 1'b1;
    step(1);
    cmp("load2 data_out", int'(data_out), 1);
    step(1);
    cmp("reload same valid", int'(valid), 1);
    load = 1'b0;
    data_in = 4'b0010;
    step(1);
    cmp("track data_out", int'(data_out), 0);
    data_in = 4'b0110;
    sel = 2'd0; load = 1'b1;
    step(1);
    load = 1'b0;
    mode = 1'b1;
    step(3);
    cmp("auto pre-step ch_out", int'(ch_out), 0);
    step(1);
    cmp("auto first step ch_out", int'(ch_out), 1);
    cmp("auto first step valid", int'(valid), 1);
    load = 1'b1; sel = 2'd3;
    step(8);
    load = 1'b0;
    step(8);
    cmp("auto wrap ch_out", int'(ch_out), 1);
    data_in = 4'b1001;
    step(6);
    mode = 1'b0;
    step(2);
    data_in = 4'b0110;
    sel = 2'd1; load = 1'b1;
    step(1);
    load = 1'b0; mode = 1'b1;
    step(6);
    cmp("midscan ch_out", int'(ch_out), 2);
    rst = 1'b1;
    step(1);
    cmp("midscan rst ch_out", int'(ch_out), 0);
    cmp("midscan rst data_out", int'(data_out), 0);
    cmp("midscan rst valid", int'(valid), 0);
    rst = 1'b0;
    step(3);
    cmp("resume hold ch_out", int'(ch_out), 0);
    step(1);
    cmp("resume step ch_out", int'(ch_out), 1);
    cmp("resume step valid", int'(valid), 1);
    mode = 1'b0; load = 1'b1; sel = 2'd3;
    step(1);
    cmp("mode+load ch_out", int'(ch_out), 3);
    mode = 1'b1; sel = 2'd0;
    step(5);
    load = 1'b0;
    cmp("auto ignores load ch_out", int'(ch_out), 0);
    mode = 1'b0;
    step(1);
`ifdef SCAN_MASK_EN
    ch_mask = 4'b1010;
    sel = 2'd1; load = 1'b1;
    step(1);
    load = 1'b0; mode = 1'b1;
    step(4);
    cmp("mask step ch_out", int'(ch_out), 3);
    step(4);
    cmp("mask wrap ch_out", int'(ch_out), 1);
    step(8);
    ch_mask = 4'b0010;
    step(8);
    ch_mask = 4'b0000;
    step(8);
    cmp("mask none ch_out", int'(ch_out), 1);
    mode = 1'b0; ch_mask = 4'b1010;
    sel = 2'd0; load = 1'b1;
    step(1);
    load = 1'b0;
    cmp("mask load ignored ch_out", int'(ch_out), 1);
    cmp("mask load ignored valid", int'(valid), 0);
    ch_mask = '1;
    step(1);
`endif
    d2_sel = 2'd1; d2_load = 1'b1;
    step(1);
    cmp("n3 load ch_out", int'(d2_ch), 1);
    cmp("n3 load data_out", int'(d2_out), 2);
    d2_sel = 2'd3;
    step(1);
    cmp("n3 oor ch_out", int'(d2_ch), 1);
    cmp("n3 oor valid", int'(d2_valid), 0);
    d2_mode = 1'b1; d2_sel = 2'd0;
    step(1);
    cmp("n3 dwell1 ch_out a", int'(d2_ch), 2);
    cmp("n3 dwell1 data_out a", int'(d2_out), 3);
    step(1);
    cmp("n3 dwell1 wrap ch_out", int'(d2_ch), 0);
    cmp("n3 dwell1 valid b", int'(d2_valid), 1);
    step(1);
    cmp("n3 dwell1 ch_out c", int'(d2_ch), 1);
    cmp("n3 dwell1 valid c", int'(d2_valid), 1);
    d2_mode = 1'b0; d2_load = 1'b0;
    step(1);
    cmp("n3 manual valid", int'(d2_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
